// File: rtl/sample_recorder_pkg.sv
// Shared types and helpers for the sample_recorder capture path.
package sample_recorder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned CHECKSUM_WIDTH = 32;

    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned sample_freq);
        return clk_freq / sample_freq;
    endfunction

endpackage

// File: rtl/sample_recorder_sync_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_WIDTH-1:0]      wdata,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  wr_en;
    logic                  rd_en;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sample_recorder.sv
// Samples in_data on an internal tick, buffers it and streams it out.
// Optional running checksum of popped data: define SAMPLE_RECORDER_CHECKSUM_EN.
module sample_recorder
    import sample_recorder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned DUT_CLK_FREQ = 100_000_000,
    parameter int unsigned SAMPLE_FREQ  = 1_000_000,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   finish,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   tick,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_last,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_WIDTH-1:0]   sample_count,
    output logic [CNT_WIDTH-1:0]   drop_count,
    output logic                   overflow,
    output logic                   done
`ifdef SAMPLE_RECORDER_CHECKSUM_EN
    ,
    output logic [CHECKSUM_WIDTH-1:0] checksum
`endif
);

    localparam int unsigned DIV = calc_div(DUT_CLK_FREQ, SAMPLE_FREQ);
    localparam int unsigned TW  = $clog2(DIV);

    state_t                state_q;
    state_t                state_d;
    logic [TW-1:0]         tick_cnt;
    logic                  start;
    logic                  push;
    logic                  pop;
    logic                  accepted;
    logic                  dropped;
    logic                  full;
    logic                  empty;
    logic [DATA_WIDTH-1:0] rdata;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign tick      = (state_q == RUN) && (tick_cnt == TW'(DIV - 1));
    assign push      = tick && in_valid;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign accepted  = push && (!full || pop);
    assign dropped   = push && full && !pop;
    assign out_data  = out_valid ? rdata : '0;
    assign out_last  = out_valid && (level == 1) && (state_q == FLUSH);
    assign done      = (state_q == DONE);
    assign start     = (state_q == IDLE) && (state_d == RUN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (enable) state_d = RUN;
            RUN:   if (finish || !enable) state_d = FLUSH;
            // Leave as soon as the last word is leaving, so done follows the final pop.
            FLUSH: if (empty || (pop && level == 1)) state_d = DONE;
            DONE:  if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (state_q == RUN && state_d == RUN) begin
            tick_cnt <= (tick_cnt == TW'(DIV - 1)) ? '0 : tick_cnt + 1'b1;
        end else begin
            tick_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_count <= '0;
            drop_count   <= '0;
            overflow     <= 1'b0;
        end else if (start) begin
            sample_count <= '0;
            drop_count   <= '0;
            overflow     <= 1'b0;
        end else begin
            if (accepted && sample_count != '1) sample_count <= sample_count + 1'b1;
            if (dropped && drop_count != '1)    drop_count   <= drop_count + 1'b1;
            if (dropped)                        overflow     <= 1'b1;
        end
    end

`ifdef SAMPLE_RECORDER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          checksum <= '0;
        else if (start)                     checksum <= '0;
        else if (pop && state_q != DONE)    checksum <= checksum + CHECKSUM_WIDTH'(rdata);
    end
`endif

endmodule
